// File: rtl/param_counter_pkg.sv
// Shared types and defaults for param_counter: FSM state encoding,
// hit counter width and the parameter defaults used by the top.
package param_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int HIT_W       = 8;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MODULUS = 16;
    localparam int DEF_TARGET  = 9;
    localparam int DEF_ONESHOT = 0;

endpackage

// File: rtl/param_counter_sat_counter.sv
// sat_counter: W-bit event counter that increments on inc_i and sticks at
// its all-ones maximum instead of wrapping.
module sat_counter
    import param_counter_pkg::*;
#(
    parameter int W = HIT_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/param_counter.sv
// Modulo up/down counter with load, target match, terminal-count pulse,
// saturating hit counter and optional one-shot stop. Define
// PARAM_COUNTER_ASSERT_EN to enable the built-in immediate assertions.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS,
    parameter int TARGET  = DEF_TARGET,
    parameter int ONESHOT = DEF_ONESHOT
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             tc,
    output logic [HIT_W-1:0] hit_cnt,
    output logic             busy,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TGT_VAL = WIDTH'(TARGET);
    localparam logic [31:0]      MOD_U   = 32'(MODULUS);

    function automatic logic in_range(input logic [WIDTH-1:0] v);
        return (32'(v) < MOD_U);
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic             at_end;
    logic             hit_inc;

    // A step is terminal when it would leave the 0..MODULUS-1 range.
    assign at_end = dir ? (count_q == MAX_VAL) : (count_q == '0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        err_d   = err_q;
        if (load) begin
            state_d = RUN;
            if (in_range(load_val)) begin
                count_d = load_val;
            end else begin
                count_d = MAX_VAL;
                err_d   = 1'b1;
            end
        end else if (en && (state_q != DONE)) begin
            state_d = RUN;
            if (at_end) begin
                tc_d = 1'b1;
                if (ONESHOT != 0) begin
                    state_d = DONE;
                end else begin
                    count_d = dir ? '0 : MAX_VAL;
                end
            end else begin
                count_d = dir ? (count_q + 1'b1) : (count_q - 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    // Only an arrival at TARGET counts; staying on it does not.
    assign hit_inc = (count_d == TGT_VAL) && (count_q != TGT_VAL);

    sat_counter #(
        .W (HIT_W)
    ) u_hit (
        .clk_i  (clk),
        .rst_ni (RST),
        .inc_i  (hit_inc),
        .cnt_o  (hit_cnt)
    );

    assign count = count_q;
    assign match = (count_q == TGT_VAL);
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);
    assign err   = err_q;

`ifdef PARAM_COUNTER_ASSERT_EN
    logic [HIT_W-1:0] hit_prev_q;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            hit_prev_q <= '0;
        end else begin
            hit_prev_q <= hit_cnt;
        end
    end

    always @(posedge clk) begin
        if (RST) begin
            a_range: assert (32'(count_q) < MOD_U)
                else $error("a_range failed at %0t", $time);
            a_match: assert (match == (count_q == TGT_VAL))
                else $error("a_match failed at %0t", $time);
            a_hit_mono: assert (hit_cnt >= hit_prev_q)
                else $error("a_hit_mono failed at %0t", $time);
        end
    end
`endif

endmodule
